// File: rtl/noc_axilite_pkg.sv
// Constants, FSM encoding and helpers shared by the AXI-lite <-> OpenPiton NoC
// request/response bridge blocks.
package noc_axilite_pkg;

    localparam int NOC_DATA_WIDTH = 64;
    localparam int PHY_ADDR_WIDTH = 40;

    localparam logic [7:0] MSG_TYPE_NC_LOAD_REQ  = 8'd14;
    localparam logic [7:0] MSG_TYPE_NC_STORE_REQ = 8'd15;

    // Tag values pushed into the response block's type FIFO
    localparam logic [1:0] MSG_TYPE_LOAD  = 2'd1;
    localparam logic [1:0] MSG_TYPE_STORE = 2'd2;

    typedef logic [2:0] req_state_t;
    localparam req_state_t ST_IDLE = 3'd0;
    localparam req_state_t ST_HDR0 = 3'd1;
    localparam req_state_t ST_HDR1 = 3'd2;
    localparam req_state_t ST_HDR2 = 3'd3;
    localparam req_state_t ST_DATA = 3'd4;

    function automatic int data_flits(input int axi_data_width);
        return axi_data_width / NOC_DATA_WIDTH;
    endfunction

    function automatic logic [63:0] byte_swap64(input logic [63:0] w);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[8*i +: 8] = w[8*(7-i) +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/noc_req_hdr_gen.sv
// Combinational formatter for the three OpenPiton header flits of a
// non-cacheable load/store request.
module noc_req_hdr_gen
    import noc_axilite_pkg::*;
#(
    parameter int         DEST_CHIPID = 0,
    parameter int         DEST_X      = 0,
    parameter int         DEST_Y      = 0,
    parameter int         SRC_CHIPID  = 0,
    parameter int         SRC_X       = 0,
    parameter int         SRC_Y       = 0,
    parameter logic [2:0] REQ_SIZE    = 3'b111
) (
    input  logic                      is_store,
    input  logic [PHY_ADDR_WIDTH-1:0] addr,
    input  logic [7:0]                payload_len,
    output logic [NOC_DATA_WIDTH-1:0] hdr0,
    output logic [NOC_DATA_WIDTH-1:0] hdr1,
    output logic [NOC_DATA_WIDTH-1:0] hdr2
);

    logic [7:0] msg_type;

    assign msg_type = is_store ? MSG_TYPE_NC_STORE_REQ : MSG_TYPE_NC_LOAD_REQ;

    // hdr0: chip[63:50] x[49:42] y[41:34] fbits[33:30] len[29:22] type[21:14] mshr[13:6] opt[5:0]
    assign hdr0 = {14'(DEST_CHIPID), 8'(DEST_X), 8'(DEST_Y), 4'd0,
                   payload_len, msg_type, 8'd0, 6'd0};

    // hdr1: addr field occupies [63:16]; data size sits in [15:13]
    assign hdr1 = {{(48-PHY_ADDR_WIDTH){1'b0}}, addr, REQ_SIZE, 13'd0};

    assign hdr2 = {14'(SRC_CHIPID), 8'(SRC_X), 8'(SRC_Y), 4'd0, 30'd0};

endmodule

// File: rtl/noc_request_axilite.sv
// AXI-lite slave that turns AR and AW+W transactions into OpenPiton
// non-cacheable load/store request packets on a single NoC output.
module noc_request_axilite
    import noc_axilite_pkg::*;
#(
    parameter int         AXI_LITE_DATA_WIDTH = 512,
    parameter int         AXI_LITE_ADDR_WIDTH = 64,
    parameter int         SWAP_ENDIANESS      = 1,
    parameter int         DEST_CHIPID         = 0,
    parameter int         DEST_X              = 0,
    parameter int         DEST_Y              = 0,
    parameter int         SRC_CHIPID          = 0,
    parameter int         SRC_X               = 0,
    parameter int         SRC_Y               = 0,
    parameter logic [2:0] REQ_SIZE            = 3'b111
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [AXI_LITE_ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic                               s_axi_arvalid,
    output logic                               s_axi_arready,
    input  logic [AXI_LITE_ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic                               s_axi_awvalid,
    output logic                               s_axi_awready,
    input  logic [AXI_LITE_DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [AXI_LITE_DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                               s_axi_wvalid,
    output logic                               s_axi_wready,
    output logic                               noc_valid_out,
    output logic [NOC_DATA_WIDTH-1:0]          noc_data_out,
    input  logic                               noc_ready_in,
    output logic                               transaction_type_wr,
    output logic [2:0]                         transaction_type_wr_data,
    input  logic                               transaction_fifo_full
);

    localparam int DATA_FLITS = data_flits(AXI_LITE_DATA_WIDTH);
    localparam int CNT_W      = (DATA_FLITS > 1) ? $clog2(DATA_FLITS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_FLITS - 1);

    req_state_t state_q, state_d;
    logic ar_vld_q, ar_vld_d;
    logic aw_vld_q, aw_vld_d;
    logic w_vld_q, w_vld_d;
    logic is_store_q, is_store_d;
    logic rr_store_q, rr_store_d;
    logic fifo_full_q, fifo_full_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [AXI_LITE_ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic [AXI_LITE_ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [AXI_LITE_DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [AXI_LITE_DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;

    logic load_pend, store_pend, sel_store, fire;
    logic [AXI_LITE_ADDR_WIDTH-1:0] req_addr;
    logic [7:0] payload_len;
    logic [NOC_DATA_WIDTH-1:0] hdr0, hdr1, hdr2, data_word;
    logic unused_bits;

    assign s_axi_arready = !ar_vld_q;
    assign s_axi_awready = !aw_vld_q;
    assign s_axi_wready  = !w_vld_q;

    assign load_pend  = ar_vld_q;
    assign store_pend = aw_vld_q && w_vld_q;
    assign sel_store  = store_pend && (!load_pend || rr_store_q);
    assign fire       = noc_valid_out && noc_ready_in;

    assign req_addr    = is_store_q ? awaddr_q : araddr_q;
    assign payload_len = is_store_q ? 8'(2 + DATA_FLITS) : 8'd2;

    // Strobes and the unused upper address bits are kept only for visibility
    assign unused_bits = ^{wstrb_q, araddr_q, awaddr_q};

    noc_req_hdr_gen #(
        .DEST_CHIPID (DEST_CHIPID),
        .DEST_X      (DEST_X),
        .DEST_Y      (DEST_Y),
        .SRC_CHIPID  (SRC_CHIPID),
        .SRC_X       (SRC_X),
        .SRC_Y       (SRC_Y),
        .REQ_SIZE    (REQ_SIZE)
    ) u_hdr_gen (
        .is_store    (is_store_q),
        .addr        (req_addr[PHY_ADDR_WIDTH-1:0]),
        .payload_len (payload_len),
        .hdr0        (hdr0),
        .hdr1        (hdr1),
        .hdr2        (hdr2)
    );

    always_comb begin
        data_word = wdata_q[NOC_DATA_WIDTH*int'(cnt_q) +: NOC_DATA_WIDTH];
        if (SWAP_ENDIANESS != 0) begin
            data_word = byte_swap64(data_word);
        end
    end

    always_comb begin
        noc_valid_out = (state_q != ST_IDLE);
        case (state_q)
            ST_HDR0: noc_data_out = hdr0;
            ST_HDR1: noc_data_out = hdr1;
            ST_HDR2: noc_data_out = hdr2;
            ST_DATA: noc_data_out = data_word;
            default: noc_data_out = '0;
        endcase
        transaction_type_wr      = (state_q == ST_HDR0) && noc_ready_in;
        transaction_type_wr_data = {is_store_q ? MSG_TYPE_STORE : MSG_TYPE_LOAD, req_addr[3]};
    end

    always_comb begin
        state_d     = state_q;
        ar_vld_d    = ar_vld_q || (s_axi_arvalid && s_axi_arready);
        aw_vld_d    = aw_vld_q || (s_axi_awvalid && s_axi_awready);
        w_vld_d     = w_vld_q  || (s_axi_wvalid  && s_axi_wready);
        is_store_d  = is_store_q;
        rr_store_d  = rr_store_q;
        fifo_full_d = transaction_fifo_full;
        cnt_d       = cnt_q;
        araddr_d    = (s_axi_arvalid && s_axi_arready) ? s_axi_araddr : araddr_q;
        awaddr_d    = (s_axi_awvalid && s_axi_awready) ? s_axi_awaddr : awaddr_q;
        wdata_d     = (s_axi_wvalid && s_axi_wready) ? s_axi_wdata : wdata_q;
        wstrb_d     = (s_axi_wvalid && s_axi_wready) ? s_axi_wstrb : wstrb_q;

        case (state_q)
            ST_IDLE: begin
                // Full flag is registered, so a release is seen one cycle late
                if (!fifo_full_q && (load_pend || store_pend)) begin
                    state_d    = ST_HDR0;
                    is_store_d = sel_store;
                    rr_store_d = !rr_store_q;
                end
            end
            ST_HDR0: if (fire) state_d = ST_HDR1;
            ST_HDR1: if (fire) state_d = ST_HDR2;
            ST_HDR2: begin
                if (fire) begin
                    if (is_store_q) begin
                        state_d = ST_DATA;
                        cnt_d   = '0;
                    end else begin
                        state_d  = ST_IDLE;
                        ar_vld_d = 1'b0;
                    end
                end
            end
            ST_DATA: begin
                if (fire) begin
                    if (cnt_q == LAST_CNT) begin
                        state_d  = ST_IDLE;
                        aw_vld_d = 1'b0;
                        w_vld_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ar_vld_q    <= 1'b0;
            aw_vld_q    <= 1'b0;
            w_vld_q     <= 1'b0;
            is_store_q  <= 1'b0;
            rr_store_q  <= 1'b0;
            fifo_full_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            ar_vld_q    <= ar_vld_d;
            aw_vld_q    <= aw_vld_d;
            w_vld_q     <= w_vld_d;
            is_store_q  <= is_store_d;
            rr_store_q  <= rr_store_d;
            fifo_full_q <= fifo_full_d;
            cnt_q       <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        araddr_q <= araddr_d;
        awaddr_q <= awaddr_d;
        wdata_q  <= wdata_d;
        wstrb_q  <= wstrb_d;
    end

endmodule

// File: tb/tb_noc_request_axilite.sv
// Directed bench for noc_request_axilite: table of single transactions plus
// hand-written arbitration, stall, FIFO-full and reset sequences.
module tb_noc_request_axilite;

    logic         clk = 1'b0;
    logic         rst;
    logic [63:0]  s_axi_araddr;
    logic         s_axi_arvalid;
    logic         s_axi_arready;
    logic [63:0]  s_axi_awaddr;
    logic         s_axi_awvalid;
    logic         s_axi_awready;
    logic [511:0] s_axi_wdata;
    logic [63:0]  s_axi_wstrb;
    logic         s_axi_wvalid;
    logic         s_axi_wready;
    logic         noc_valid_out;
    logic [63:0]  noc_data_out;
    logic         noc_ready_in;
    logic         transaction_type_wr;
    logic [2:0]   transaction_type_wr_data;
    logic         transaction_fifo_full;

    int checks = 0;
    int errors = 0;
    logic [63:0] flits[$];
    logic [2:0]  pushes[$];

    noc_request_axilite dut (
        .clk                      (clk),
        .rst                      (rst),
        .s_axi_araddr             (s_axi_araddr),
        .s_axi_arvalid            (s_axi_arvalid),
        .s_axi_arready            (s_axi_arready),
        .s_axi_awaddr             (s_axi_awaddr),
        .s_axi_awvalid            (s_axi_awvalid),
        .s_axi_awready            (s_axi_awready),
        .s_axi_wdata              (s_axi_wdata),
        .s_axi_wstrb              (s_axi_wstrb),
        .s_axi_wvalid             (s_axi_wvalid),
        .s_axi_wready             (s_axi_wready),
        .noc_valid_out            (noc_valid_out),
        .noc_data_out             (noc_data_out),
        .noc_ready_in             (noc_ready_in),
        .transaction_type_wr      (transaction_type_wr),
        .transaction_type_wr_data (transaction_type_wr_data),
        .transaction_fifo_full    (transaction_fifo_full)
    );

    always #5 clk = ~clk;

    // Inputs change only at posedge+1, so negedge values are what the next edge sees
    always @(negedge clk) begin
        if (!rst && noc_valid_out && noc_ready_in) flits.push_back(noc_data_out);
        if (!rst && transaction_type_wr) pushes.push_back(transaction_type_wr_data);
    end

    typedef struct {
        logic        is_store;
        logic [63:0] addr;
        logic [63:0] w0;
        int          nflits;
        logic [2:0]  push;
        logic [63:0] hdr0;
        logic [63:0] hdr1;
        logic [63:0] d0;
    } vec_t;

    vec_t vecs[5];

    localparam logic [63:0] LOAD_HDR0  = 64'h0000_0000_0083_8000;
    localparam logic [63:0] STORE_HDR0 = 64'h0000_0000_0283_C000;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] fl(input int i);
        return (i < flits.size()) ? flits[i] : 64'hDEAD_BEEF_DEAD_BEEF;
    endfunction

    function automatic logic [2:0] pu(input int i);
        return (i < pushes.size()) ? pushes[i] : 3'bxxx;
    endfunction

    function automatic logic [63:0] bswap(input logic [63:0] w);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = w[56-8*i +: 8];
        return r;
    endfunction

    function automatic logic [511:0] mkdata(input logic [63:0] w0);
        logic [511:0] d;
        for (int i = 0; i < 8; i++) d[64*i +: 64] = w0 + 64'(i);
        return d;
    endfunction

    task automatic clear_q();
        flits.delete();
        pushes.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_axi_arvalid = 1'b0;
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        noc_ready_in  = 1'b1;
        transaction_fifo_full = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic send_ar(input logic [63:0] a);
        int n = 0;
        s_axi_araddr = a;
        s_axi_arvalid = 1'b1;
        while (!s_axi_arready && n < 100) begin tick(); n++; end
        chk("ar_accept", n < 100, 1);
        tick();
        s_axi_arvalid = 1'b0;
    endtask

    task automatic send_store(input logic [63:0] a, input logic [63:0] w0);
        int n = 0;
        s_axi_awaddr = a;
        s_axi_wdata = mkdata(w0);
        s_axi_wstrb = '1;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid = 1'b1;
        while (!(s_axi_awready && s_axi_wready) && n < 100) begin tick(); n++; end
        chk("store_accept", n < 100, 1);
        tick();
        s_axi_awvalid = 1'b0;
        s_axi_wvalid = 1'b0;
    endtask

    task automatic run_until(input int k, input string nm);
        int c = 0;
        noc_ready_in = 1'b1;
        while (flits.size() < k && c < 200) begin tick(); c++; end
        chk({nm, "_reach"}, c < 200, 1);
    endtask

    task automatic wait_flits(input int n, input string nm);
        int c = 0;
        while (flits.size() < n && c < 300) begin tick(); c++; end
        chk({nm, "_timeout"}, c < 300, 1);
        repeat (3) tick();
        chk({nm, "_count"}, flits.size(), n);
        chk({nm, "_idle"}, noc_valid_out, 0);
    endtask

    logic [63:0] held;
    logic        stable;

    initial begin
        s_axi_araddr = '0;
        s_axi_awaddr = '0;
        s_axi_wdata  = '0;
        s_axi_wstrb  = '0;

        vecs[0] = '{1'b0, 64'h0000_0000_8000_0048, 64'h0, 3, 3'b011,
                    LOAD_HDR0, 64'h0000_8000_0048_E000, 64'h0};
        vecs[1] = '{1'b1, 64'h0000_0000_8000_0100, 64'h0102030405060708, 11, 3'b100,
                    STORE_HDR0, 64'h0000_8000_0100_E000, 64'h0807060504030201};
        vecs[2] = '{1'b0, 64'h0000_0000_1234_5670, 64'h0, 3, 3'b010,
                    LOAD_HDR0, 64'h0000_1234_5670_E000, 64'h0};
        vecs[3] = '{1'b0, 64'hFFFF_FF00_0000_0008, 64'h0, 3, 3'b011,
                    LOAD_HDR0, 64'h0000_0000_0008_E000, 64'h0};
        vecs[4] = '{1'b1, 64'h0000_00AB_CDEF_0128, 64'h1122334455667788, 11, 3'b101,
                    STORE_HDR0, 64'h00AB_CDEF_0128_E000, 64'h8877665544332211};

        do_reset();
        chk("rst_valid", noc_valid_out, 0);
        chk("rst_type_wr", transaction_type_wr, 0);
        chk("rst_arready", s_axi_arready, 1);
        chk("rst_awready", s_axi_awready, 1);
        chk("rst_wready", s_axi_wready, 1);

        for (int v = 0; v < 5; v++) begin
            clear_q();
            if (vecs[v].is_store) send_store(vecs[v].addr, vecs[v].w0);
            else send_ar(vecs[v].addr);
            wait_flits(vecs[v].nflits, $sformatf("vec%0d", v));
            chk($sformatf("vec%0d_hdr0", v), fl(0), vecs[v].hdr0);
            chk($sformatf("vec%0d_hdr1", v), fl(1), vecs[v].hdr1);
            chk($sformatf("vec%0d_hdr2", v), fl(2), 64'h0);
            chk($sformatf("vec%0d_npush", v), pushes.size(), 1);
            chk($sformatf("vec%0d_push", v), pu(0), vecs[v].push);
            if (vecs[v].is_store) begin
                chk($sformatf("vec%0d_d0", v), fl(3), vecs[v].d0);
                for (int i = 1; i < 8; i++)
                    chk($sformatf("vec%0d_d%0d", v, i), fl(3 + i), bswap(vecs[v].w0 + 64'(i)));
            end
        end

        // W three cycles ahead of AW
        clear_q();
        s_axi_wdata = mkdata(64'h0102030405060708);
        s_axi_wvalid = 1'b1;
        tick();
        s_axi_wvalid = 1'b0;
        chk("wfirst_wready", s_axi_wready, 0);
        repeat (3) tick();
        chk("wfirst_wait_valid", noc_valid_out, 0);
        s_axi_awaddr = 64'h0000_0000_8000_0100;
        s_axi_awvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0;
        chk("wfirst_lat1", noc_valid_out, 0);
        tick();
        chk("wfirst_lat2", noc_valid_out, 1);
        wait_flits(11, "wfirst");
        chk("wfirst_hdr0", fl(0), STORE_HDR0);
        chk("wfirst_flit3", fl(3), 64'h0807060504030201);
        chk("wfirst_push", pu(0), 3'b100);

        // Round-robin from a known pointer
        do_reset();
        for (int r = 0; r < 2; r++) begin
            clear_q();
            s_axi_araddr = 64'h0000_0000_8000_0048;
            s_axi_awaddr = 64'h0000_0000_8000_0100;
            s_axi_wdata  = mkdata(64'h0102030405060708);
            s_axi_arvalid = 1'b1;
            s_axi_awvalid = 1'b1;
            s_axi_wvalid  = 1'b1;
            tick();
            s_axi_arvalid = 1'b0;
            s_axi_awvalid = 1'b0;
            s_axi_wvalid  = 1'b0;
            wait_flits(14, $sformatf("rr%0d", r));
            chk($sformatf("rr%0d_first", r), fl(0), LOAD_HDR0);
            chk($sformatf("rr%0d_second", r), fl(3), STORE_HDR0);
            chk($sformatf("rr%0d_npush", r), pushes.size(), 2);
            chk($sformatf("rr%0d_push0", r), pu(0), 3'b011);
            chk($sformatf("rr%0d_push1", r), pu(1), 3'b100);
        end

        // Back-pressure during HDR1 of a load
        clear_q();
        send_ar(64'h0000_0000_8000_0048);
        run_until(1, "stall_hdr1");
        noc_ready_in = 1'b0;
        held = noc_data_out;
        stable = 1'b1;
        repeat (5) begin
            tick();
            if (!noc_valid_out || noc_data_out !== held) stable = 1'b0;
        end
        chk("stall_hdr1_stable", stable, 1);
        chk("stall_hdr1_value", held, 64'h0000_8000_0048_E000);
        noc_ready_in = 1'b1;
        wait_flits(3, "stall_hdr1");
        chk("stall_hdr1_npush", pushes.size(), 1);

        // Back-pressure mid-DATA of a store
        clear_q();
        send_store(64'h0000_0000_8000_0100, 64'h0102030405060708);
        run_until(5, "stall_data");
        noc_ready_in = 1'b0;
        held = noc_data_out;
        stable = 1'b1;
        repeat (5) begin
            tick();
            if (!noc_valid_out || noc_data_out !== held) stable = 1'b0;
        end
        chk("stall_data_stable", stable, 1);
        chk("stall_data_value", held, bswap(64'h0102030405060708 + 64'd2));
        noc_ready_in = 1'b1;
        wait_flits(11, "stall_data");
        chk("stall_data_word2", fl(5), bswap(64'h0102030405060708 + 64'd2));
        chk("stall_data_word3", fl(6), bswap(64'h0102030405060708 + 64'd3));
        chk("stall_data_npush", pushes.size(), 1);

        // Type FIFO full holds off a pending load
        clear_q();
        transaction_fifo_full = 1'b1;
        send_ar(64'h0000_0000_8000_0048);
        stable = 1'b1;
        repeat (4) begin
            tick();
            if (noc_valid_out) stable = 1'b0;
        end
        chk("full_hold", stable, 1);
        transaction_fifo_full = 1'b0;
        tick();
        chk("full_rel_lat1", noc_valid_out, 0);
        tick();
        chk("full_rel_lat2", noc_valid_out, 1);
        transaction_fifo_full = 1'b1;
        wait_flits(3, "full_inflight");
        chk("full_inflight_npush", pushes.size(), 1);
        transaction_fifo_full = 1'b0;

        // Reset while flit 4 (second data word) is on the wire
        clear_q();
        send_store(64'h0000_0000_8000_0100, 64'h0102030405060708);
        run_until(4, "rst_mid");
        chk("rst_mid_busy", noc_valid_out, 1);
        rst = 1'b1;
        tick();
        chk("rst_mid_valid", noc_valid_out, 0);
        chk("rst_mid_type_wr", transaction_type_wr, 0);
        chk("rst_mid_arready", s_axi_arready, 1);
        chk("rst_mid_awready", s_axi_awready, 1);
        chk("rst_mid_wready", s_axi_wready, 1);
        rst = 1'b0;
        clear_q();
        send_ar(64'h0000_0000_1234_5670);
        wait_flits(3, "post_rst");
        chk("post_rst_hdr0", fl(0), LOAD_HDR0);
        chk("post_rst_hdr1", fl(1), 64'h0000_1234_5670_E000);
        chk("post_rst_push", pu(0), 3'b010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/noc_request_axilite.md
Name: noc_request_axilite

Overview:
AXI-lite slave-side request packetiser: accepts AR, AW and W channel transactions from the Ara/CVA6 master and emits OpenPiton NoC request packets (non-cacheable load/store) on one NoC output. It is the request-direction counterpart of noc_response_axilite. Per issued packet it also pushes a 3-bit transaction tag into that block's type FIFO, so responses are steered to the R or B channel.

Parameters:
AXI_LITE_DATA_WIDTH, 512, AXI data width; integer multiple of `NOC_DATA_WIDTH (64).
AXI_LITE_ADDR_WIDTH, 64, AXI address width; low `PHY_ADDR_WIDTH bits used.
SWAP_ENDIANESS, 1, byte-reverse each 64-bit store word before sending.
DEST_CHIPID, 0, destination chip id written into header0.
DEST_X, 0, destination X coordinate.
DEST_Y, 0, destination Y coordinate.
SRC_CHIPID / SRC_X / SRC_Y, 0 / 0 / 0, source fields written into header2.
REQ_SIZE, 3'b111, header1 data-size field (64B); applied to both loads and stores.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
s_axi_araddr  in  AXI_LITE_ADDR_WIDTH  read address
s_axi_arvalid  in  1
s_axi_arready  out  1
s_axi_awaddr  in  AXI_LITE_ADDR_WIDTH  write address
s_axi_awvalid  in  1
s_axi_awready  out  1
s_axi_wdata  in  AXI_LITE_DATA_WIDTH
s_axi_wstrb  in  AXI_LITE_DATA_WIDTH/8  captured only; not encoded (full-line stores)
s_axi_wvalid  in  1
s_axi_wready  out  1
noc_valid_out  out  1  NoC request flit valid
noc_data_out  out  `NOC_DATA_WIDTH  NoC request flit
noc_ready_in  in  1
transaction_type_wr  out  1  one-cycle push into response type FIFO
transaction_type_wr_data  out  3  {msg type [2:1] (2'd1 load, 2'd2 store), addr[3]}
transaction_fifo_full  in  1  response type FIFO full; blocks new packets

Behaviour:
- Single-entry capture buffers for AR, AW, W, each with a valid flag. xREADY = !flag; capture on xVALID&&xREADY; flag clears when the packet consuming it finishes its last flit. AW and W are captured independently, in either order.
- Store pending = AW flag && W flag. Load pending = AR flag.
- FSM states: IDLE, HDR0, HDR1, HDR2, DATA.
- IDLE: if a request is pending and !transaction_fifo_full, select it and go to HDR0. If both are pending, a round-robin pointer picks one; it toggles after every issued packet. The pointer resets to load-first.
- HDR0: header0 = DEST_CHIPID/X/Y, length (2 for load, 2+AXI_LITE_DATA_WIDTH/64 for store), type `MSG_TYPE_NC_LOAD_REQ or `MSG_TYPE_NC_STORE_REQ, MSHR id 0. On handshake: transaction_type_wr=1 for exactly that cycle; go to HDR1.
- HDR1: address[`PHY_ADDR_WIDTH-1:0] plus REQ_SIZE. On handshake go to HDR2.
- HDR2: SRC_CHIPID/X/Y. On handshake, a load goes to IDLE and clears AR; a store goes to DATA with word counter 0.
- DATA: flit i = wdata[64*i +: 64], byte-reversed when SWAP_ENDIANESS. On handshake the counter increments. On the last word, clear the AW and W flags and go to IDLE.
- noc_valid_out = (state != IDLE). noc_data_out is combinational from state and buffers, and holds stable while valid && !ready. No flit is ever dropped or repeated.
- Latency: capture to HDR0 valid is 2 cycles (capture edge, IDLE decision edge).
- A buffer whose flag clears may be refilled in the same cycle via its ready only from the next cycle (ready is registered via the flag).
- transaction_fifo_full is sampled only in IDLE; it never interrupts a packet in flight.
- Reset mid-packet: FSM → IDLE, all flags and counter → 0, RR pointer → load. Outputs noc_valid_out=0, transaction_type_wr=0, all xREADY=1 in the first cycle after reset.

Decomposition:
- Shared package noc_axilite_pkg: MSG_TYPE_LOAD/STORE 2-bit tag values (shared with noc_response_axilite), FSM state enum, flit-count helper constant DATA_FLITS = AXI_LITE_DATA_WIDTH/64.
- One sub-module: noc_req_hdr_gen (combinational header0/1/2 formatter from type, address, length).

Test Plan:
- Single load: AR addr 0x8000_0048 → 3 flits; header0 length 2, type NC_LOAD_REQ; header1 addr 0x8000_0048; type push data 3'b011.
- Single store, W before AW by 3 cycles, 512-bit data, word0=0x0102030405060708 → 11 flits; flit 3 = 0x0807060504030201; push data 3'b100.
- AR and store pending in the same cycle, twice in succession → order load, store, load, store; exactly one type push per packet.
- noc_ready_in held low 5 cycles during HDR1 and mid-DATA → noc_data_out unchanged throughout; no extra pushes.
- transaction_fifo_full=1 with load pending → stays IDLE, valid 0. Release → HDR0 two cycles later.
- Assert rst during DATA flit 4 → next cycle valid=0, all xREADY=1; a fresh load afterwards works normally.
